// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU and a DMA/debug master.
// The CPU owns the port by default; DMA bursts are bounded and followed by a cooldown cycle.
module dmem_arbiter #(
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 3,
  parameter int BURST_MAX    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_write,
  input  logic [DATA_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX);

  typedef enum logic [1:0] {ST_CPU, ST_DMA, ST_COOL} state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic              dma_done_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              cpu_access;
  logic              gnt_raw;
  logic              gnt;

  assign cpu_access = cpu_read | cpu_write;

  always_comb begin
    gnt_raw     = 1'b0;
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      ST_CPU:  gnt_raw = dma_req & (~cpu_access | (wait_cnt_q == WAIT_MAX));
      ST_DMA:  gnt_raw = dma_req;
      default: gnt_raw = 1'b0;
    endcase
    // Reset masks the grant so nothing reaches memory while held in reset.
    gnt = gnt_raw & reset;

    case (state_q)
      ST_CPU: begin
        if (gnt) begin
          burst_cnt_d = BW'(1);
          state_d     = (BURST_MAX == 1) ? ST_COOL : ST_DMA;
        end
      end
      ST_DMA: begin
        if (gnt) begin
          burst_cnt_d = burst_cnt_q + BW'(1);
          if (burst_cnt_d == BURST_LAST) state_d = ST_COOL;
        end else begin
          state_d = ST_CPU;
        end
      end
      default: state_d = ST_CPU;
    endcase

    if (gnt || !dma_req) wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_CPU;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
      dma_done_q  <= 1'b0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      dma_done_q  <= gnt;
      if (gnt && !dma_write) dma_rdata_q <= mem_rdata;
    end
  end

  // Port mux: DMA drives memory only in its granted cycles.
  assign dma_gnt   = gnt;
  assign cpu_stall = cpu_access & gnt;
  assign mem_addr  = gnt ? dma_addr  : cpu_addr;
  assign mem_wdata = gnt ? dma_wdata : cpu_wdata;
  assign mem_read  = reset & (gnt ? ~dma_write : cpu_read);
  assign mem_write = reset & (gnt ?  dma_write : cpu_write);
  assign cpu_rdata = mem_rdata;
  assign dma_done  = dma_done_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory on the shared port.
module tb_dmem_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_read, cpu_write, cpu_stall;
  logic        dma_req, dma_write, dma_gnt, dma_done;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [15:0] mem [0:255] = '{default: 16'h0000};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:0]];

  dmem_arbiter #(.DATA_W(16), .STARVE_LIMIT(3), .BURST_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [5:0] burst_exp;
    logic [8:0] force_exp;
    logic [4:0] fresh_exp;
    int k;

    // Reset held for two cycles with both masters requesting a write
    reset = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 16'hDEAD;
    dma_req = 1'b1; dma_write = 1'b1; dma_addr = 16'h0051; dma_wdata = 16'hBEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_gnt", dma_gnt, 0);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_done", dma_done, 0);
      chk("rst_rdata", dma_rdata, 16'h0000);
    end
    chk("rst_mem_addr", mem_addr, 16'h0050);
    tick();
    reset = 1'b1; cpu_write = 1'b0; dma_req = 1'b0;
    #1;
    chk("rst_no_write50", mem[8'h50], 16'h0000);
    chk("rst_no_write51", mem[8'h51], 16'h0000);

    // CPU preloads 0x0020 for the later DMA read
    cpu_write = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    #1;
    chk("cpu_wr_mem_write", mem_write, 1);
    tick();
    cpu_write = 1'b0;

    // Idle-CPU burst: 4 grants, 1 cooldown, then grant again
    burst_exp = 6'b101111;
    k = 0;
    dma_req = 1'b1; dma_write = 1'b1;
    for (int c = 0; c < 6; c++) begin
      dma_addr = 16'h0010 + 16'(k); dma_wdata = 16'hA000 + 16'(k);
      #1;
      chk($sformatf("burst_gnt%0d", c), dma_gnt, burst_exp[c]);
      if (c == 1) chk("burst_done1", dma_done, 1);
      if (c == 5) chk("burst_done_after_cool", dma_done, 0);
      tick();
      if (burst_exp[c]) k++;
    end
    dma_req = 1'b0;
    #1;
    chk("burst_release_gnt", dma_gnt, 0);
    tick();
    for (int i = 0; i < 5; i++)
      chk($sformatf("burst_mem%0d", i), mem[8'h10 + 8'(i)], 16'hA000 + 16'(i));

    // Forced grant: CPU reads every cycle, DMA waits STARVE_LIMIT cycles
    force_exp = 9'b001111000;
    cpu_read = 1'b1; cpu_addr = 16'h0012;
    dma_req = 1'b1; dma_write = 1'b1; dma_addr = 16'h0060; dma_wdata = 16'hBEEF;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk($sformatf("force_gnt%0d", c), dma_gnt, force_exp[c]);
      chk($sformatf("force_stall%0d", c), cpu_stall, force_exp[c]);
      if (c == 0) begin
        chk("force_cpu_read", mem_read, 1);
        chk("force_cpu_rdata", cpu_rdata, 16'hA002);
      end
      if (c == 3) begin
        chk("force_mem_write", mem_write, 1);
        chk("force_mem_addr", mem_addr, 16'h0060);
      end
      tick();
    end
    dma_req = 1'b0; cpu_read = 1'b0;
    tick();
    chk("force_mem60", mem[8'h60], 16'hBEEF);

    // Single DMA read
    dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0020;
    #1;
    chk("rd_gnt", dma_gnt, 1);
    chk("rd_mem_read", mem_read, 1);
    chk("rd_mem_write", mem_write, 0);
    tick();
    dma_req = 1'b0; cpu_read = 1'b1; cpu_addr = 16'h0010;
    #1;
    chk("rd_done", dma_done, 1);
    chk("rd_data", dma_rdata, 16'h1234);
    tick();
    chk("rd_done_clear", dma_done, 0);
    chk("rd_data_hold", dma_rdata, 16'h1234);
    cpu_read = 1'b0;

    // Release hand-off: DMA drops request while CPU write is pending
    dma_req = 1'b1; dma_write = 1'b1; dma_addr = 16'h0070; dma_wdata = 16'h7777;
    #1;
    chk("ho_gnt", dma_gnt, 1);
    tick();
    dma_req = 1'b0; cpu_write = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
    #1;
    chk("ho_stall", cpu_stall, 0);
    chk("ho_gnt_rel", dma_gnt, 0);
    chk("ho_mem_write", mem_write, 1);
    chk("ho_mem_addr", mem_addr, 16'h0030);
    tick();
    cpu_write = 1'b0; cpu_read = 1'b1; dma_req = 1'b1;
    #1;
    chk("ho_state_cpu", dma_gnt, 0);
    chk("ho_mem30", cpu_rdata, 16'h5555);
    tick();
    dma_req = 1'b0; cpu_read = 1'b0;
    tick();

    // Reset on the 2nd grant of a burst
    dma_req = 1'b1; dma_write = 1'b1; dma_addr = 16'h0080; dma_wdata = 16'hC000;
    #1;
    chk("mid_gnt0", dma_gnt, 1);
    tick();
    dma_addr = 16'h0081; dma_wdata = 16'hC001; reset = 1'b0;
    #1;
    chk("mid_rst_gnt", dma_gnt, 0);
    chk("mid_rst_write", mem_write, 0);
    tick();
    reset = 1'b1;
    fresh_exp = 5'b01111;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      dma_addr = 16'h0090 + 16'(k); dma_wdata = 16'hC100 + 16'(k);
      #1;
      if (c == 0) chk("mid_done_cleared", dma_done, 0);
      chk($sformatf("mid_fresh_gnt%0d", c), dma_gnt, fresh_exp[c]);
      tick();
      if (fresh_exp[c]) k++;
    end
    dma_req = 1'b0;
    tick();
    chk("mid_mem80", mem[8'h80], 16'hC000);
    chk("mid_mem81", mem[8'h81], 16'h0000);
    chk("mid_mem93", mem[8'h93], 16'hC103);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter that shares the single data-memory port (DMemory_IO) between the PMIPSL0 processor and a secondary bus master (DMA/debug loader). It sits between the processor's dmem* signals and the memory device. It grants the port to the processor by default. DMA gets the port opportunistically when the CPU is idle, and is forced in after a bounded wait. A burst limit plus a mandatory cooldown cycle guarantees the CPU is never starved. When the CPU loses a cycle, cpu_stall holds its PC and register writes.

## Interface
- DATA_W, 16, address/data width
- STARVE_LIMIT, 3, consecutive denied DMA-request cycles before the DMA grant is forced (≥1)
- BURST_MAX, 4, maximum consecutive DMA grants before a cooldown cycle (≥1)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- cpu_addr, cpu_wdata  in  DATA_W  processor data-memory address / write data
- cpu_read, cpu_write  in  1  processor read / write enables
- cpu_rdata  out  DATA_W  equals mem_rdata (combinational)
- cpu_stall  out  1  processor access not serviced this cycle; CPU must hold
- dma_req  in  1  DMA wants one word access this cycle
- dma_write  in  1  1 = write, 0 = read (valid with dma_req)
- dma_addr, dma_wdata  in  DATA_W  DMA address / write data
- dma_gnt  out  1  DMA owns the port this cycle (combinational)
- dma_done  out  1  one-cycle pulse, cycle after each granted DMA access
- dma_rdata  out  DATA_W  registered read data of the last granted DMA read
- mem_addr, mem_wdata  out  DATA_W  to memory
- mem_read, mem_write  out  1  to memory
- mem_rdata  in  DATA_W  from memory (combinational read, write on clock edge)

## Operation
- cpu_access = cpu_read | cpu_write.
- States: CPU, DMA, COOL. Reset state: CPU.
- CPU state:
  - dma_gnt = dma_req & (~cpu_access | wait_cnt == STARVE_LIMIT).
  - On a grant: go to DMA with burst_cnt = 1. If BURST_MAX == 1, go to COOL instead.
- DMA state:
  - dma_gnt = dma_req.
  - On a grant, burst_cnt increments. When it reaches BURST_MAX, go to COOL.
  - If dma_req = 0: no grant; the CPU is routed and serviced this cycle; go to CPU.
- COOL state: dma_gnt = 0 for exactly one cycle, CPU routed, then go to CPU.
- cpu_stall = cpu_access & dma_gnt.
- Port mux:
  - When dma_gnt = 1, mem_* carry the dma_* signals: mem_write = dma_write, mem_read = ~dma_write.
  - Otherwise mem_* carry the cpu_* signals.
- wait_cnt (saturating at STARVE_LIMIT):
  - Increments when dma_req & ~dma_gnt.
  - Clears on any grant, or when dma_req = 0.
- On a granted read, dma_rdata <= mem_rdata at the clock edge. It holds otherwise.
- dma_done <= dma_gnt (registered).
- During reset (reset = 0): dma_gnt, cpu_stall, mem_read and mem_write are forced to 0, so no memory write occurs.
  - Registers load: state CPU, wait_cnt 0, burst_cnt 0, dma_done 0, dma_rdata 0.

## Timing
- Reset values: dma_done 0, dma_rdata 0, dma_gnt 0, cpu_stall 0, mem_read/mem_write 0. mem_addr/mem_wdata follow the CPU inputs.
- DMA write commits at the clock edge that ends the grant cycle. DMA read data appears on dma_rdata one cycle after the grant, with dma_done = 1.
- Worst-case DMA latency with the CPU continuously busy: STARVE_LIMIT denied cycles, then grant on the next cycle.
- Worst-case CPU loss: BURST_MAX consecutive stall cycles, followed by a guaranteed CPU cycle (COOL).
- Back-to-back DMA accesses: one per cycle while in DMA state.
- dma_req sampled low in DMA state releases the port in the same cycle; no dead cycle.
- Reset mid-burst: the next cycle is in CPU state with counters 0. A pending dma_done from the last pre-reset grant is cleared.
- dma_req = 1 while cpu_access = 0 in COOL: no grant. wait_cnt increments.

## Test plan
- Reset: hold reset = 0 for 2 cycles with cpu_write = 1 and dma_req = 1. Required: mem_write = 0, dma_gnt = 0, dma_done = 0, dma_rdata = 0x0000.
- Idle-CPU burst: cpu_access = 0, dma_req held with writes to 0x0010–0x0014, data 0xA000–0xA004.
  - Required: gnt for 4 cycles (0x0010–0x0013), then 1 COOL cycle with gnt = 0, then gnt resumes for 0x0014.
  - Memory holds all five values.
- Forced grant: CPU reads every cycle, dma_req held from cycle 0.
  - Required: gnt = 0 for cycles 0–2, then gnt = 1 with cpu_stall = 1 at cycle 3.
  - CPU stalled until the burst ends or the request drops.
- DMA read: memory[0x0020] = 0x1234, single-cycle dma_req read. Required: the next cycle has dma_done = 1 and dma_rdata = 0x1234, and dma_rdata holds afterwards.
- Release hand-off: in DMA state, drop dma_req while cpu_write to 0x0030 with data 0x5555 is pending. Required: same cycle cpu_stall = 0, mem_write = 1, memory[0x0030] = 0x5555; state returns to CPU.
- Reset mid-burst: assert reset = 0 on the 2nd grant of a burst. Required: no write on that edge. After release, an idle-CPU request receives a full fresh BURST_MAX = 4 grants.
